// File: rtl/sd_sector_scheduler_pkg.sv
// Shared definitions for the SD sector scheduler.
//   sd_sched_state_t : scheduler FSM encoding
//   SECTOR_BYTES     : bytes moved per granted transfer
package sd_sched_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} sd_sched_state_t;

  localparam int SECTOR_BYTES = 512;

endpackage

// File: rtl/sd_sector_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   ptr     : highest-priority index this round
//   gnt     : one-hot grant (0 when no request)
//   gnt_idx : binary index of the granted requester
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;
  logic           found;

  // Lower half keeps only requests at or above ptr; upper half holds the full
  // vector so the scan wraps around to indices below ptr.
  always_comb begin
    mask    = ~((N'(1) << ptr) - N'(1));
    dbl     = {req, req & mask};
    found   = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < 2*N; i++) begin
      if (!found && dbl[i]) begin
        found   = 1'b1;
        gnt_idx = IW'(i % N);
      end
    end
    gnt = found ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/sd_sector_scheduler.sv
// Round-robin scheduler sharing one SD controller between track pipelines.
//   clk, rst            : clock, synchronous active-high reset
//   req, req_write      : per-track sector request and direction (1 = write)
//   rewind              : per-track pulse, returns the sector counter to 0
//   grant, done         : one-hot owner, one-cycle completion pulse
//   sd_ready, byte_strobe : controller ready, one pulse per byte moved
//   sd_rd, sd_wr, sd_addr : registered controller command
//   busy                : high whenever the FSM is not idle
//
// state | meaning
// IDLE  | no owner; arbitrate among requests
// ISSUE | owner chosen, address valid; wait for sd_ready
// XFER  | enable held; count byte strobes up to a full sector
// DONE  | one cycle; pulse done, advance sector index and rr pointer
module sd_sector_scheduler
  import sd_sched_pkg::*;
#(
  parameter int NUM_TRACKS  = 4,
  parameter int SECTOR_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_TRACKS-1:0] req,
  input  logic [NUM_TRACKS-1:0] req_write,
  input  logic [NUM_TRACKS-1:0] rewind,
  output logic [NUM_TRACKS-1:0] grant,
  output logic [NUM_TRACKS-1:0] done,
  input  logic                  sd_ready,
  input  logic                  byte_strobe,
  output logic                  sd_rd,
  output logic                  sd_wr,
  output logic [31:0]           sd_addr,
  output logic                  busy
);

  localparam int TW = $clog2(NUM_TRACKS);
  localparam logic [9:0] LAST_BYTE = 10'(SECTOR_BYTES - 1);

  sd_sched_state_t        state;
  logic                   dir;
  logic [9:0]             byte_cnt;
  logic [TW-1:0]          rr_ptr;
  logic [TW-1:0]          cur;
  logic [NUM_TRACKS-1:0]  rew_pend;
  logic [SECTOR_BITS-1:0] sector_idx [NUM_TRACKS];

  logic [NUM_TRACKS-1:0]  arb_gnt;
  logic [TW-1:0]          arb_idx;
  logic [31:0]            addr_next;

  rr_arbiter #(.N(NUM_TRACKS), .IW(TW)) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    addr_next = 32'({arb_idx, sector_idx[arb_idx], 9'b0});
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      done     <= '0;
      dir      <= 1'b0;
      sd_rd    <= 1'b0;
      sd_wr    <= 1'b0;
      sd_addr  <= '0;
      byte_cnt <= '0;
      rr_ptr   <= '0;
      cur      <= '0;
      rew_pend <= '0;
      for (int i = 0; i < NUM_TRACKS; i++) sector_idx[i] <= '0;
    end else begin
      done <= '0;

      // A rewind of the owning track is deferred to DONE so the running
      // transfer keeps its address; other tracks clear immediately.
      for (int i = 0; i < NUM_TRACKS; i++) begin
        if (rewind[i]) begin
          if (grant[i]) rew_pend[i]   <= 1'b1;
          else          sector_idx[i] <= '0;
        end
      end

      unique case (state)
        IDLE: begin
          if (|req) begin
            grant   <= arb_gnt;
            cur     <= arb_idx;
            dir     <= req_write[arb_idx];
            sd_addr <= addr_next;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (sd_ready) begin
            sd_wr    <= dir;
            sd_rd    <= !dir;
            byte_cnt <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (byte_strobe) begin
            byte_cnt <= byte_cnt + 10'd1;
            if (byte_cnt == LAST_BYTE) begin
              sd_rd <= 1'b0;
              sd_wr <= 1'b0;
              done  <= grant;
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (rew_pend[cur] || rewind[cur]) sector_idx[cur] <= '0;
          else sector_idx[cur] <= sector_idx[cur] + SECTOR_BITS'(1);
          rew_pend[cur] <= 1'b0;
          rr_ptr        <= cur + TW'(1);
          grant         <= '0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_sector_scheduler.sv
module tb_sd_sector_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, req_write, rewind;
  logic        sd_ready, byte_strobe;
  logic [3:0]  grant, done;
  logic        sd_rd, sd_wr, busy;
  logic [31:0] sd_addr;
  // second instance with a tiny sector field so index wrap is reachable
  logic [3:0]  d2_grant, d2_done;
  logic        d2_sd_rd, d2_sd_wr, d2_busy;
  logic [31:0] d2_sd_addr;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sd_sector_scheduler #(.NUM_TRACKS(4), .SECTOR_BITS(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_write(req_write), .rewind(rewind),
    .grant(grant), .done(done), .sd_ready(sd_ready), .byte_strobe(byte_strobe),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_addr(sd_addr), .busy(busy)
  );

  sd_sector_scheduler #(.NUM_TRACKS(4), .SECTOR_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .req(req), .req_write(req_write), .rewind(rewind),
    .grant(d2_grant), .done(d2_done), .sd_ready(sd_ready), .byte_strobe(byte_strobe),
    .sd_rd(d2_sd_rd), .sd_wr(d2_sd_wr), .sd_addr(d2_sd_addr), .busy(d2_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] addr16(input int t, input int idx);
    return (32'(t) << 25) | (32'(idx & 16'hFFFF) << 9);
  endfunction

  function automatic logic [31:0] addr2(input int t, input int idx);
    return (32'(t) << 11) | (32'(idx & 3) << 9);
  endfunction

  // Full transfer for one track; idx is the expected sector index in the
  // 16-bit instance (the 2-bit instance sees the same index modulo 4).
  task automatic run_xfer(input int t, input bit wr, input int idx, input string tag);
    req = 4'(1 << t); req_write = wr ? 4'(1 << t) : 4'b0;
    sd_ready = 1'b1; byte_strobe = 1'b1;
    tick();
    chk({tag, "_grant"}, 32'(grant), 32'(1 << t));
    chk({tag, "_addr"}, sd_addr, addr16(t, idx));
    chk({tag, "_addr2"}, d2_sd_addr, addr2(t, idx));
    tick();
    chk({tag, "_wr"}, 32'(sd_wr), 32'(wr));
    repeat (512) tick();
    chk({tag, "_done"}, 32'(done), 32'(1 << t));
    req = '0; byte_strobe = 1'b0;
    tick();
  endtask

  logic [3:0] wr_pat;

  initial begin
    rst = 1'b1; req = '0; req_write = '0; rewind = '0;
    sd_ready = 1'b0; byte_strobe = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_addr", sd_addr, 32'h0);
    chk("rst_rdwr", 32'({sd_rd, sd_wr}), 32'h0);
    chk("rst_done", 32'(done), 32'h0);

    // single load on track 1
    req = 4'b0010; req_write = 4'b0000; sd_ready = 1'b1;
    tick();
    chk("load_grant", 32'(grant), 32'h2);
    chk("load_addr", sd_addr, 32'h0200_0000);
    chk("load_busy", 32'(busy), 32'h1);
    chk("load_rd_early", 32'(sd_rd), 32'h0);
    tick();
    chk("load_rd", 32'(sd_rd), 32'h1);
    chk("load_wr", 32'(sd_wr), 32'h0);
    byte_strobe = 1'b1;
    repeat (511) tick();
    chk("load_511_rd", 32'(sd_rd), 32'h1);
    chk("load_511_done", 32'(done), 32'h0);
    tick();
    byte_strobe = 1'b0; req = '0;
    chk("load_512_rd", 32'(sd_rd), 32'h0);
    chk("load_done", 32'(done), 32'h2);
    tick();
    chk("load_done_pulse", 32'(done), 32'h0);
    chk("load_idle_grant", 32'(grant), 32'h0);
    chk("load_idle_busy", 32'(busy), 32'h0);

    // store on track 1 with sd_ready low 100 cycles and strobes during ISSUE
    sd_ready = 1'b0; req = 4'b0010; req_write = 4'b0010;
    tick();
    chk("stall_addr", sd_addr, 32'h0200_0200);
    byte_strobe = 1'b1;
    repeat (100) tick();
    chk("stall_rdwr", 32'({sd_rd, sd_wr}), 32'h0);
    chk("stall_grant", 32'(grant), 32'h2);
    byte_strobe = 1'b0; sd_ready = 1'b1;
    tick();
    chk("stall_wr", 32'(sd_wr), 32'h1);
    chk("stall_rd", 32'(sd_rd), 32'h0);
    byte_strobe = 1'b1;
    repeat (511) tick();
    chk("store_511_wr", 32'(sd_wr), 32'h1);
    chk("store_511_done", 32'(done), 32'h0);
    tick();
    chk("store_512_wr", 32'(sd_wr), 32'h0);
    chk("store_done", 32'(done), 32'h2);
    byte_strobe = 1'b0; req = '0;
    tick();

    // reset in the middle of a transfer on track 2
    req = 4'b0100; req_write = 4'b0000;
    tick();
    chk("rx_addr", sd_addr, 32'h0400_0000);
    tick();
    byte_strobe = 1'b1;
    repeat (200) tick();
    chk("rx_rd", 32'(sd_rd), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0; byte_strobe = 1'b0; req = '0;
    chk("rx_grant", 32'(grant), 32'h0);
    chk("rx_rdwr", 32'({sd_rd, sd_wr}), 32'h0);
    chk("rx_addr0", sd_addr, 32'h0);
    chk("rx_busy", 32'(busy), 32'h0);
    chk("rx_done", 32'(done), 32'h0);
    chk("rx_addr2", d2_sd_addr, 32'h0);

    // fairness: all tracks requesting, strobes continuous
    wr_pat = 4'b0101;
    req = 4'b1111; req_write = wr_pat; sd_ready = 1'b1; byte_strobe = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int t;
      t = k % 4;
      tick();
      chk("fair_grant", 32'(grant), 32'(1 << t));
      chk("fair_grant2", 32'(d2_grant), 32'(1 << t));
      chk("fair_addr", sd_addr, addr16(t, k / 4));
      tick();
      chk("fair_wr", 32'(sd_wr), 32'(wr_pat[t]));
      chk("fair_rd", 32'(sd_rd), 32'(!wr_pat[t]));
      repeat (511) tick();
      chk("fair_511", 32'(done), 32'h0);
      tick();
      chk("fair_done", 32'(done), 32'(1 << t));
      tick();
    end
    req = '0; byte_strobe = 1'b0;
    tick();

    // rewind of an idle track takes effect at once (track 1 was at idx 1)
    rewind = 4'b0010;
    tick();
    rewind = '0;
    run_xfer(1, 1'b0, 0, "rew_idle");

    // bring track 2 from idx 1 to idx 5
    run_xfer(2, 1'b0, 1, "pump1");
    run_xfer(2, 1'b1, 2, "pump2");
    run_xfer(2, 1'b0, 3, "pump3");
    run_xfer(2, 1'b1, 4, "pump4");

    // rewind of the owning track mid-transfer
    req = 4'b0100; req_write = 4'b0000; sd_ready = 1'b1; byte_strobe = 1'b1;
    tick();
    chk("rew_addr", sd_addr, 32'h0400_0A00);
    tick();
    repeat (100) tick();
    rewind = 4'b0100;
    tick();
    rewind = '0;
    chk("rew_addr_hold", sd_addr, 32'h0400_0A00);
    chk("rew_rd_hold", 32'(sd_rd), 32'h1);
    repeat (410) tick();
    chk("rew_511", 32'(done), 32'h0);
    tick();
    chk("rew_done", 32'(done), 32'h4);
    req = '0; byte_strobe = 1'b0;
    tick();
    run_xfer(2, 1'b0, 0, "rew_after");

    // sector index wrap on track 3 (2-bit instance wraps 3 -> 0)
    run_xfer(3, 1'b1, 1, "wrap1");
    run_xfer(3, 1'b0, 2, "wrap2");
    run_xfer(3, 1'b1, 3, "wrap3");
    run_xfer(3, 1'b0, 4, "wrap4");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
